// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB around a shared
// datapath, drives mux selects and write enables, counts retirements, traps on faults.
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             alu_src_b,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             illegal,
    output logic             bus_err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_LOAD   = 3'd0,
        C_STORE  = 3'd1,
        C_BRANCH = 3'd2,
        C_OPIMM  = 3'd3,
        C_OP     = 3'd4,
        C_LUI    = 3'd5,
        C_JAL    = 3'd6,
        C_JALR   = 3'd7
    } cls_t;

    // The counter only ever needs to hold TIMEOUT-1: that value plus a low ready traps.
    localparam int                WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int                WAIT_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_LAST);

    state_t              r_state;
    cls_t                r_cls;
    logic [WAIT_W-1:0]   r_wait;
    logic [CNT_W-1:0]    r_retired;
    logic                r_illegal;
    logic                r_bus_err;

    state_t              w_state_nxt;
    cls_t                w_cls_dec;
    logic                w_legal;
    logic                w_retire;
    logic                w_set_illegal;
    logic                w_set_bus_err;
    logic                w_wait_inc;
    logic                w_wait_expired;
    logic                w_src_imm;

    assign w_wait_expired = (TIMEOUT != 0) && (r_wait == WAIT_LIMIT);
    assign w_src_imm      = (r_cls != C_OP) && (r_cls != C_BRANCH);

    always_comb begin
        w_legal   = 1'b1;
        w_cls_dec = C_LOAD;
        case (opcode)
            7'b0000011: w_cls_dec = C_LOAD;
            7'b0100011: w_cls_dec = C_STORE;
            7'b1100011: w_cls_dec = C_BRANCH;
            7'b0010011: w_cls_dec = C_OPIMM;
            7'b0110011: w_cls_dec = C_OP;
            7'b0110111: w_cls_dec = C_LUI;
            7'b1101111: w_cls_dec = C_JAL;
            7'b1100111: w_cls_dec = C_JALR;
            default:    w_legal   = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        w_wait_inc    = 1'b0;
        imem_req      = 1'b0;
        ir_we         = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        alu_src_b     = 1'b0;
        reg_we        = 1'b0;
        wb_sel        = 2'd0;
        pc_we         = 1'b0;
        pc_sel        = 2'd0;

        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we       = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_wait_expired) begin
                    w_set_bus_err = 1'b1;
                    w_state_nxt   = S_TRAP;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_set_illegal = 1'b1;
                    w_state_nxt   = S_TRAP;
                end
            end
            S_EXEC: begin
                alu_src_b = w_src_imm;
                case (r_cls)
                    C_BRANCH: begin
                        pc_we       = 1'b1;
                        pc_sel      = branch_taken ? 2'd1 : 2'd0;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                    C_LOAD, C_STORE: w_state_nxt = S_MEM;
                    default:         w_state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                alu_src_b = w_src_imm;
                dmem_req  = 1'b1;
                dmem_we   = (r_cls == C_STORE);
                if (dmem_ready) begin
                    if (r_cls == C_STORE) begin
                        pc_we       = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_wait_expired) begin
                    w_set_bus_err = 1'b1;
                    w_state_nxt   = S_TRAP;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_WB: begin
                alu_src_b   = w_src_imm;
                reg_we      = 1'b1;
                pc_we       = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
                case (r_cls)
                    C_LOAD: wb_sel = 2'd1;
                    C_LUI:  wb_sel = 2'd3;
                    C_JAL: begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd1;
                    end
                    C_JALR: begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd2;
                    end
                    default: wb_sel = 2'd0;
                endcase
            end
            S_TRAP:  w_state_nxt = S_TRAP;
            default: w_state_nxt = S_TRAP;
        endcase

        // Outputs are held quiet for the whole time reset is asserted, not just after the edge.
        if (!reset_n) begin
            imem_req  = 1'b0;
            ir_we     = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            alu_src_b = 1'b0;
            reg_we    = 1'b0;
            wb_sel    = 2'd0;
            pc_we     = 1'b0;
            pc_sel    = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_cls     <= C_LOAD;
            r_wait    <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DECODE) begin
                r_cls <= w_cls_dec;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            // Any state change restarts the wait count, covering entry to FETCH and MEM.
            if (w_state_nxt != r_state) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    assign state_o = r_state;
    assign retired = r_retired;
    assign illegal = r_illegal;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle checks of state, controls and flags
// through each instruction class, traps, timeouts and reset.
module tb_multicycle_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [6:0]       opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             branch_taken;
    logic             imem_req;
    logic             ir_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             alu_src_b;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             illegal;
    logic             bus_err;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retired;

    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_ret;

    multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .alu_src_b(alu_src_b), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we),
        .pc_sel(pc_sel), .illegal(illegal), .bus_err(bus_err), .state_o(state_o),
        .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ex(input int st, input int ireq, input int irwe,
                                       input int dreq, input int dwe, input int srcb,
                                       input int rwe, input int wbs, input int pcwe,
                                       input int pcs);
        return {st[2:0], ireq[0], irwe[0], dreq[0], dwe[0], srcb[0], rwe[0],
                wbs[1:0], pcwe[0], pcs[1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs and flags at the falling edge, then step to just after the next rise.
    task automatic cyc(input string tag, input logic [13:0] e,
                       input logic ill = 1'b0, input logic berr = 1'b0);
        @(negedge clk);
        check({tag, "_ctl"}, 32'({state_o, imem_req, ir_we, dmem_req, dmem_we, alu_src_b,
                                  reg_we, wb_sel, pc_we, pc_sel}), 32'(e));
        check({tag, "_flags"}, 32'({retired, illegal, bus_err}), 32'({exp_ret, ill, berr}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        opcode       = 7'h00;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        branch_taken = 1'b0;
        exp_ret      = '0;
        @(posedge clk);
        #1;
        cyc("reset", ex(0,0,0,0,0,0,0,0,0,0));
        reset_n = 1'b1;

        // addi
        opcode = 7'h13; imem_ready = 1'b1;
        cyc("addi_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        cyc("addi_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("addi_exec",   ex(2,0,0,0,0,1,0,0,0,0));
        cyc("addi_wb",     ex(4,0,0,0,0,1,1,0,1,0));
        exp_ret++;

        // load with three wait cycles in MEM
        opcode = 7'h03;
        cyc("ld_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        cyc("ld_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("ld_exec",   ex(2,0,0,0,0,1,0,0,0,0));
        dmem_ready = 1'b0;
        repeat (3) cyc("ld_mem_wait", ex(3,0,0,1,0,1,0,0,0,0));
        dmem_ready = 1'b1;
        cyc("ld_mem_done", ex(3,0,0,1,0,1,0,0,0,0));
        dmem_ready = 1'b0;
        cyc("ld_wb", ex(4,0,0,0,0,1,1,1,1,0));
        exp_ret++;

        // branch taken, then not taken
        opcode = 7'h63; branch_taken = 1'b1;
        cyc("brt_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        cyc("brt_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("brt_exec",   ex(2,0,0,0,0,0,0,0,1,1));
        exp_ret++;
        branch_taken = 1'b0;
        cyc("brn_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        cyc("brn_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("brn_exec",   ex(2,0,0,0,0,0,0,0,1,0));
        exp_ret++;

        // jal, jalr
        opcode = 7'h6F;
        cyc("jal_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        cyc("jal_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("jal_exec",   ex(2,0,0,0,0,1,0,0,0,0));
        cyc("jal_wb",     ex(4,0,0,0,0,1,1,2,1,1));
        exp_ret++;
        opcode = 7'h67;
        cyc("jalr_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        cyc("jalr_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("jalr_exec",   ex(2,0,0,0,0,1,0,0,0,0));
        cyc("jalr_wb",     ex(4,0,0,0,0,1,1,2,1,2));
        exp_ret++;

        // store with immediate dmem_ready
        opcode = 7'h23; dmem_ready = 1'b1;
        cyc("st_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        cyc("st_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("st_exec",   ex(2,0,0,0,0,1,0,0,0,0));
        cyc("st_mem",    ex(3,0,0,1,1,1,0,0,1,0));
        exp_ret++;
        dmem_ready = 1'b0;

        // lui, op
        opcode = 7'h37;
        cyc("lui_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        cyc("lui_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("lui_exec",   ex(2,0,0,0,0,1,0,0,0,0));
        cyc("lui_wb",     ex(4,0,0,0,0,1,1,3,1,0));
        exp_ret++;
        opcode = 7'h33;
        cyc("op_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        cyc("op_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("op_exec",   ex(2,0,0,0,0,0,0,0,0,0));
        cyc("op_wb",     ex(4,0,0,0,0,0,1,0,1,0));
        exp_ret++;

        // eight more branches: 9 -> 17, which wraps the 4-bit counter to 1
        opcode = 7'h63;
        for (int i = 0; i < 8; i++) begin
            cyc("wrap_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
            cyc("wrap_decode", ex(1,0,0,0,0,0,0,0,0,0));
            cyc("wrap_exec",   ex(2,0,0,0,0,0,0,0,1,0));
            exp_ret++;
        end

        // illegal opcode traps and stays trapped
        opcode = 7'h7F;
        cyc("ill_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        cyc("ill_decode", ex(1,0,0,0,0,0,0,0,0,0));
        repeat (20) cyc("ill_trap", ex(5,0,0,0,0,0,0,0,0,0), 1'b1, 1'b0);
        reset_n = 1'b0; exp_ret = '0;
        cyc("ill_reset", ex(0,0,0,0,0,0,0,0,0,0));
        reset_n = 1'b1;

        // fetch timeout: four low cycles then TRAP with bus_err
        opcode = 7'h13; imem_ready = 1'b0;
        repeat (4) cyc("to_fetch_wait", ex(0,1,0,0,0,0,0,0,0,0));
        cyc("to_trap", ex(5,0,0,0,0,0,0,0,0,0), 1'b0, 1'b1);
        cyc("to_trap_hold", ex(5,0,0,0,0,0,0,0,0,0), 1'b0, 1'b1);
        reset_n = 1'b0;
        cyc("to_reset", ex(0,0,0,0,0,0,0,0,0,0));
        reset_n = 1'b1;

        // ready on the fourth cycle wins; then reset in the middle of MEM
        opcode = 7'h03;
        repeat (3) cyc("edge_fetch_wait", ex(0,1,0,0,0,0,0,0,0,0));
        imem_ready = 1'b1;
        cyc("edge_fetch_ok", ex(0,1,1,0,0,0,0,0,0,0));
        imem_ready = 1'b0;
        cyc("edge_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("edge_exec",   ex(2,0,0,0,0,1,0,0,0,0));
        repeat (2) cyc("edge_mem_wait", ex(3,0,0,1,0,1,0,0,0,0));
        reset_n = 1'b0;
        cyc("mem_reset", ex(0,0,0,0,0,0,0,0,0,0));
        reset_n = 1'b1;

        // data-side timeout in MEM
        imem_ready = 1'b1;
        cyc("mto_fetch",  ex(0,1,1,0,0,0,0,0,0,0));
        imem_ready = 1'b0;
        cyc("mto_decode", ex(1,0,0,0,0,0,0,0,0,0));
        cyc("mto_exec",   ex(2,0,0,0,0,1,0,0,0,0));
        repeat (4) cyc("mto_mem_wait", ex(3,0,0,1,0,1,0,0,0,0));
        cyc("mto_trap", ex(5,0,0,0,0,0,0,0,0,0), 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback around the shared datapath: instruction register, immediate generator, ALU, register file, PC mux and memory ports. Decodes the opcode class once per instruction and drives mux selects and write enables. Counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT, 255, max wait cycles for imem_ready/dmem_ready before bus error; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  7  inst[6:0] from instruction register
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
branch_taken  in  1  branch compare result from ALU, valid in EXEC
imem_req  out  1  instruction fetch request
ir_we  out  1  instruction register load
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
alu_src_b  out  1  0 = rs2, 1 = immediate
reg_we  out  1  register file write
wb_sel  out  2  0 = ALU, 1 = mem data, 2 = PC+4, 3 = immediate (LUI)
pc_we  out  1  PC update
pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result (JALR, bit0 cleared by datapath)
illegal  out  1  sticky illegal-opcode flag
bus_err  out  1  sticky timeout flag
state_o  out  3  current state encoding
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n = 0: state = FETCH, class register cleared, wait counter = 0, retired = 0, illegal = 0, bus_err = 0, all other outputs 0. Reset may be asserted in any state; it aborts the instruction with no partial writes, and the next state after release is FETCH.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5. Codes 6 and 7 go to TRAP.
- Outputs are combinational from state, the latched class, and ready/branch_taken. Only the state, class, counters and flags are registered.
- FETCH: imem_req = 1 every cycle until imem_ready. In the cycle where imem_ready = 1, ir_we = 1 and the next state is DECODE.
- DECODE: one cycle. Latch the class from opcode: LOAD 0000011, STORE 0100011, BRANCH 1100011, OPIMM 0010011, OP 0110011, LUI 0110111, JAL 1101111, JALR 1100111. Any other opcode sets illegal = 1 and goes to TRAP. Otherwise go to EXEC.
- alu_src_b = 1 in EXEC, MEM and WB for every class except OP and BRANCH.
- EXEC: one cycle.
  - BRANCH: pc_we = 1; pc_sel = 1 if branch_taken, else 0; retire; go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other classes: go to WB.
- MEM: dmem_req = 1, and dmem_we = 1 for STORE, until dmem_ready.
  - On dmem_ready, LOAD goes to WB.
  - On dmem_ready, STORE sets pc_we = 1, pc_sel = 0, retires, and goes to FETCH.
- WB: one cycle. reg_we = 1, pc_we = 1, retire, go to FETCH.
  - OPIMM and OP: wb_sel = 0, pc_sel = 0.
  - LOAD: wb_sel = 1, pc_sel = 0.
  - LUI: wb_sel = 3, pc_sel = 0.
  - JAL: wb_sel = 2, pc_sel = 1.
  - JALR: wb_sel = 2, pc_sel = 2.
- Retire: retired increments by 1 in the same cycle as the final pc_we and wraps modulo 2^CNT_W.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle the relevant ready is low.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT with ready still low, set bus_err = 1 and go to TRAP.
  - A ready arriving in the same cycle the count reaches TIMEOUT wins: normal transition, no bus_err.
- TRAP: absorbing until reset. All enables and requests are 0. illegal and bus_err hold their values.
- Minimum instruction latency, with ready high on first request: BRANCH 3 cycles, OP/OPIMM/LUI/JAL/JALR 4, STORE 4, LOAD 5.

Test Plan:
- addi (opcode 0x13), imem_ready high -> states 0,1,2,4; in WB cycle reg_we = 1, wb_sel = 0, pc_we = 1, pc_sel = 0; retired 0 -> 1; next cycle imem_req = 1.
- Load, dmem_ready low 3 cycles then high -> MEM held 4 cycles with dmem_req = 1, dmem_we = 0; then WB with wb_sel = 1; total 8 cycles; retired + 1.
- Branch 0x63 with branch_taken = 1, then again with branch_taken = 0 -> EXEC pulses pc_we with pc_sel = 1, then pc_sel = 0; reg_we never asserted; each instruction 3 cycles.
- JAL then JALR -> WB wb_sel = 2 with pc_sel = 1, then pc_sel = 2; store 0x23 -> MEM dmem_we = 1; reg_we stays 0 for the store.
- Opcode 0x7F -> DECODE then TRAP (state_o = 5), illegal = 1, imem_req stays 0 for 20 cycles; reset_n pulse -> illegal = 0, FETCH.
- TIMEOUT = 4, imem_ready held low -> bus_err = 1 and TRAP after the 4th wait cycle. Second run: imem_ready rises exactly on the 4th cycle -> DECODE, bus_err = 0. Third run: reset_n asserted mid-MEM -> reg_we/pc_we never pulse and retired stays 0.
